sd_clk_monitor: RTL and testbench
=================================

# sd_clk_monitor

Receive-side companion to the SD clock divider. It samples the divided SD clock through a synchronizer and produces single-cycle rising and falling edge strobes in the CLK domain. It measures each half-period and reports lock against the expected divider setting, and flags a stopped clock. It sits on the controller side of the SD_CLK pad loopback and feeds the CMD/DAT shifters and the status register.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive matching half-periods required to assert LOCKED.
- TOL, 1: allowed absolute deviation, in CLK cycles, of a half-period from the expected value.
- TIMEOUT, 1024: CLK cycles without an edge before the clock is declared lost.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  reset, synchronous and active-low.
- SD_CLK_IN  in  1  asynchronous SD clock from the pad loopback.
- EXPECT_DIV  in  8  divider value currently programmed; expected half-period = EXPECT_DIV+1.
- CLR  in  1  synchronous clear of lock/lost state, active-high.
- RISE_STB  out  1  one-cycle pulse per synchronized rising edge.
- FALL_STB  out  1  one-cycle pulse per synchronized falling edge.
- HALF_PERIOD  out  9  length of the last completed half-period, in CLK cycles; saturates at 511.
- LOCKED  out  1  clock matches EXPECT_DIV.
- LOST  out  1  sticky; no edge for TIMEOUT cycles while acquiring or locked.
- MISMATCH  out  1  one-cycle pulse when a half-period fails the match while LOCKED.
- DUTY_ERR  out  1  only with SD_CLK_MON_DUTY_EN; see Configuration.

## Operation
- Synchronizer: two flops (s1, s2), then a history flop s3. An edge is detected when s2 differs from s3; its direction is given by s2.
- Gap counter `cnt` is sized to hold TIMEOUT and saturates at TIMEOUT.
  - On an edge: measured value = cnt+1, capped at 511; `cnt` is reset to 0.
  - Otherwise: `cnt` increments.
- Match condition: |measured − (EXPECT_DIV+1)| ≤ TOL. Comparison uses 10-bit unsigned arithmetic. EXPECT_DIV is sampled at each edge.
- FSM, with `mcnt` counting matches:
  - IDLE: on the first edge, go to ACQ. That measurement is discarded, HALF_PERIOD is not updated, and `mcnt` = 0. Timeout has no effect in IDLE.
  - ACQ:
    - Match: `mcnt`+1. When `mcnt` reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: `mcnt` = 0 and stay in ACQ.
    - `cnt` = TIMEOUT: go to LOST.
  - LOCKED:
    - Mismatch: pulse MISMATCH, go to ACQ with `mcnt` = 0.
    - `cnt` = TIMEOUT: go to LOST.
  - LOST: edges still generate strobes and update HALF_PERIOD. Only CLR exits this state.
- Priority, highest first: RST, then CLR, then edge, then timeout.
  - CLR in any state: go to IDLE, clear `cnt`, `mcnt` and HALF_PERIOD. Strobes for an edge detected in the same cycle are still issued.
  - An edge in the same cycle that `cnt` reaches TIMEOUT counts as an edge; no timeout occurs.
- LOCKED = (state == LOCKED). LOST = (state == LOST).

## Timing
- Reset: all outputs 0, state IDLE, `cnt` = `mcnt` = 0, s1/s2/s3 = 0.
- Strobe latency: a SD_CLK_IN transition that meets setup before CLK edge k gives a RISE_STB/FALL_STB pulse that is high in the cycle after edge k+2. That is 3 CLK edges of latency.
- HALF_PERIOD, LOCKED, LOST and MISMATCH update on the same CLK edge that asserts the strobe.
- Input toggling every N CLK cycles gives HALF_PERIOD = N.
- Timeout: LOST asserts TIMEOUT+1 CLK edges after the last strobe assertion.
- Reset asserted mid-lock takes effect on the next CLK edge, with outputs at their reset values.

## Configuration
- Macro SD_CLK_MON_DUTY_EN.
- Defined:
  - The high and low half-periods are kept in separate registers.
  - DUTY_ERR pulses on any edge, outside IDLE, where the two most recent opposite-polarity half-periods differ by more than TOL.
  - A duty error counts as a mismatch in ACQ and LOCKED.
  - HIGH and LOW registers clear on RST and CLR.
- Undefined: DUTY_ERR port and duty logic are absent; behaviour is otherwise identical.

## Test plan
- Lock: EXPECT_DIV=3, SD_CLK_IN toggles every 4 CLK → HALF_PERIOD=4. LOCKED rises with the 5th edge strobe (1 discarded + 4 matches), and strobes alternate rise/fall.
- Tolerance: EXPECT_DIV=3, half-periods alternating 4/5/4/5 → LOCKED. Half-periods of 6 → stays in ACQ, LOCKED=0.
- Mismatch after lock: lock at 4, then one half-period of 7 → MISMATCH one-cycle pulse and LOCKED=0. Resumed half-periods of 4 → relock after 4 matching edges.
- Stopped clock: lock, then hold SD_CLK_IN → LOST=1 exactly 1025 CLK edges after the last strobe. LOST holds while toggling resumes; a CLR pulse → IDLE with LOST=0 and HALF_PERIOD=0.
- Reset and CLR: RST low mid-lock → all outputs 0 on the next edge. CLR in the same cycle as an edge → strobe issued and state goes to IDLE.
- Duty (SD_CLK_MON_DUTY_EN): EXPECT_DIV=3, high=3, low=5 → DUTY_ERR pulses and LOCKED never asserts. High=low=4 → LOCKED and DUTY_ERR=0.

Source files
------------

// File: rtl/sd_clk_monitor.sv
// sd_clk_monitor
// Receive-side monitor for the divided SD clock returned through the pad
// loopback. Synchronizes SD_CLK_IN into the CLK domain, emits single-cycle
// edge strobes, measures every half-period, tracks lock against the
// programmed divider and flags a stopped clock.
//
// Optional feature macro: SD_CLK_MON_DUTY_EN (adds the DUTY_ERR output and
// high/low duty-cycle comparison).
//
// Ports:
//   CLK          system clock, all logic on its rising edge
//   RST          synchronous active-low reset
//   SD_CLK_IN    asynchronous SD clock from the pad loopback
//   EXPECT_DIV   programmed divider; expected half-period = EXPECT_DIV+1
//   CLR          synchronous clear of lock/lost state, active-high
//   RISE_STB     one-cycle pulse per synchronized rising edge
//   FALL_STB     one-cycle pulse per synchronized falling edge
//   HALF_PERIOD  last completed half-period in CLK cycles, saturates at 511
//   LOCKED       clock matches EXPECT_DIV
//   LOST         sticky, no edge for TIMEOUT cycles while acquiring/locked
//   MISMATCH     one-cycle pulse when a half-period fails while LOCKED
//   DUTY_ERR     one-cycle pulse on a high/low half-period disagreement
//                (SD_CLK_MON_DUTY_EN only)
module sd_clk_monitor #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TOL        = 1,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SD_CLK_IN,
    input  logic [7:0] EXPECT_DIV,
    input  logic       CLR,
    output logic       RISE_STB,
    output logic       FALL_STB,
    output logic [8:0] HALF_PERIOD,
    output logic       LOCKED,
    output logic       LOST,
    output logic       MISMATCH
`ifdef SD_CLK_MON_DUTY_EN
    ,
    output logic       DUTY_ERR
`endif
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCKED,
        ST_LOST
    } state_t;

    state_t        state_q;
    logic          s1_q, s2_q, s3_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mcnt_q, mcnt_inc;
    logic [8:0]    hp_q;
    logic          rise_q, fall_q, mism_q;

    logic          edge_det;
    logic          timeout_hit;
    logic          period_ok;
    logic          duty_bad;
    logic [8:0]    meas;

    function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        edge_det    = s2_q ^ s3_q;
        timeout_hit = (cnt_q == CW'(TIMEOUT));
        cnt_d       = timeout_hit ? cnt_q : cnt_q + 1'b1;
        // Gap of cnt cycles since the last edge is a half-period of cnt+1.
        meas        = ((32'(cnt_q) + 32'd1) > 32'd511) ? 9'd511 : 9'(cnt_q + 1'b1);
        period_ok   = 32'(absdiff({1'b0, meas}, {2'b00, EXPECT_DIV} + 10'd1)) <= TOL;
        mcnt_inc    = mcnt_q + 1'b1;
    end

`ifdef SD_CLK_MON_DUTY_EN
    logic [8:0] high_q, low_q, other;
    logic       duty_q;

    // A rising edge closes a low half-period, so compare against the last
    // high one (and vice versa). An empty register means no history yet.
    always_comb begin
        other    = s2_q ? high_q : low_q;
        duty_bad = edge_det && (state_q != ST_IDLE) && (other != 9'd0) &&
                   (32'(absdiff({1'b0, meas}, {1'b0, other})) > TOL);
    end

    assign DUTY_ERR = duty_q;
`else
    assign duty_bad = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            hp_q    <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            mism_q  <= 1'b0;
`ifdef SD_CLK_MON_DUTY_EN
            high_q  <= '0;
            low_q   <= '0;
            duty_q  <= 1'b0;
`endif
        end else begin
            s1_q   <= SD_CLK_IN;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            // Strobes are issued even when CLR wins over the edge.
            rise_q <= edge_det & s2_q;
            fall_q <= edge_det & ~s2_q;
            mism_q <= 1'b0;
`ifdef SD_CLK_MON_DUTY_EN
            duty_q <= 1'b0;
`endif
            if (CLR) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                mcnt_q  <= '0;
                hp_q    <= '0;
`ifdef SD_CLK_MON_DUTY_EN
                high_q  <= '0;
                low_q   <= '0;
`endif
            end else if (edge_det) begin
                cnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        // First edge only establishes a reference point.
                        state_q <= ST_ACQ;
                        mcnt_q  <= '0;
                    end
                    ST_ACQ: begin
                        hp_q <= meas;
                        if (!period_ok || duty_bad) begin
                            mcnt_q <= '0;
                        end else begin
                            mcnt_q <= mcnt_inc;
                            if (mcnt_inc == MW'(LOCK_COUNT)) state_q <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        hp_q <= meas;
                        if (!period_ok || duty_bad) begin
                            mism_q  <= 1'b1;
                            state_q <= ST_ACQ;
                            mcnt_q  <= '0;
                        end
                    end
                    ST_LOST: begin
                        hp_q <= meas;
                    end
                endcase
`ifdef SD_CLK_MON_DUTY_EN
                if (state_q != ST_IDLE) begin
                    duty_q <= duty_bad;
                    if (s2_q) low_q  <= meas;
                    else      high_q <= meas;
                end
`endif
            end else begin
                cnt_q <= cnt_d;
                if (timeout_hit && (state_q == ST_ACQ || state_q == ST_LOCKED))
                    state_q <= ST_LOST;
            end
        end
    end

    assign RISE_STB    = rise_q;
    assign FALL_STB    = fall_q;
    assign HALF_PERIOD = hp_q;
    assign LOCKED      = (state_q == ST_LOCKED);
    assign LOST        = (state_q == ST_LOST);
    assign MISMATCH    = mism_q;

endmodule

// File: tb/tb_sd_clk_monitor.sv
// Directed testbench for sd_clk_monitor: lock, tolerance, mismatch, timeout,
// reset, CLR-with-edge and (with SD_CLK_MON_DUTY_EN) duty-cycle checks.
module tb_sd_clk_monitor;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SD_CLK_IN = 1'b0;
    logic [7:0] EXPECT_DIV = 8'd3;
    logic       CLR = 1'b0;
    logic       RISE_STB, FALL_STB, LOCKED, LOST, MISMATCH;
    logic [8:0] HALF_PERIOD;
`ifdef SD_CLK_MON_DUTY_EN
    logic       DUTY_ERR;
`endif

    sd_clk_monitor #(
        .LOCK_COUNT(4),
        .TOL(1),
        .TIMEOUT(1024)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SD_CLK_IN(SD_CLK_IN),
        .EXPECT_DIV(EXPECT_DIV),
        .CLR(CLR),
        .RISE_STB(RISE_STB),
        .FALL_STB(FALL_STB),
        .HALF_PERIOD(HALF_PERIOD),
        .LOCKED(LOCKED),
        .LOST(LOST),
        .MISMATCH(MISMATCH)
`ifdef SD_CLK_MON_DUTY_EN
        ,
        .DUTY_ERR(DUTY_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Values sampled at the strobe cycle of the last half() call.
    logic [31:0] s_rise, s_fall, s_hp, s_lk, s_mm, s_ls;
    int          stb_n, mm_n, lk_seen, du_seen, lost_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Toggle SD_CLK_IN, then hold it for n CLK cycles. The strobe for this
    // toggle lands on the third falling edge (3 CLK edges of latency).
    task automatic half(input int n);
        SD_CLK_IN = ~SD_CLK_IN;
        stb_n = 0;
        mm_n  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (RISE_STB || FALL_STB) stb_n++;
            if (MISMATCH) mm_n++;
            if (LOCKED) lk_seen++;
`ifdef SD_CLK_MON_DUTY_EN
            if (DUTY_ERR) du_seen++;
`endif
            if (i == 2) begin
                s_rise = 32'(RISE_STB);
                s_fall = 32'(FALL_STB);
                s_hp   = 32'(HALF_PERIOD);
                s_lk   = 32'(LOCKED);
                s_mm   = 32'(MISMATCH);
                s_ls   = 32'(LOST);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lk_seen = 0;
        du_seen = 0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_rise", 32'(RISE_STB), 0);
        chk("rst_fall", 32'(FALL_STB), 0);
        chk("rst_hp", 32'(HALF_PERIOD), 0);
        chk("rst_locked", 32'(LOCKED), 0);
        chk("rst_lost", 32'(LOST), 0);
        chk("rst_mm", 32'(MISMATCH), 0);
        RST = 1'b1;
        @(negedge CLK);

        // Lock at half-period 4 with EXPECT_DIV=3
        EXPECT_DIV = 8'd3;
        half(4);
        chk("lock_e1_rise", s_rise, 1);
        chk("lock_e1_fall", s_fall, 0);
        chk("lock_e1_hp", s_hp, 0);
        chk("lock_e1_stbn", 32'(stb_n), 1);
        half(4);
        chk("lock_e2_fall", s_fall, 1);
        chk("lock_e2_rise", s_rise, 0);
        chk("lock_e2_hp", s_hp, 4);
        half(4);
        half(4);
        chk("lock_e4_locked", s_lk, 0);
        half(4);
        chk("lock_e5_locked", s_lk, 1);
        chk("lock_e5_hp", s_hp, 4);

        // Mismatch after lock: one half-period of 7
        half(7);
        chk("mm_pre_locked", s_lk, 1);
        half(4);
        chk("mm_pulse", s_mm, 1);
        chk("mm_pulse_width", 32'(mm_n), 1);
        chk("mm_locked", s_lk, 0);
        chk("mm_hp", s_hp, 7);
        half(4);
        half(4);
        half(4);
        chk("relock_e3_locked", s_lk, 0);
        half(4);
        chk("relock_e4_locked", s_lk, 1);

        // Stopped clock: LOST after TIMEOUT+1 edges past the last strobe
        lost_at = 0;
        for (int j = 2; j <= 1100 && lost_at == 0; j++) begin
            @(negedge CLK);
            if (LOST) lost_at = j;
        end
        chk("lost_delay", 32'(lost_at), 1025);
        chk("lost_locked", 32'(LOCKED), 0);
        half(4);
        chk("lost_hp_sat", s_hp, 511);
        chk("lost_sticky1", s_ls, 1);
        half(4);
        chk("lost_hp", s_hp, 4);
        chk("lost_sticky2", s_ls, 1);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clr_lost", 32'(LOST), 0);
        chk("clr_hp", 32'(HALF_PERIOD), 0);
        chk("clr_locked", 32'(LOCKED), 0);

        // Tolerance: 4/5 alternating locks; 6 never matches EXPECT_DIV=3
        half(4);
        half(5);
        half(4);
        half(5);
        chk("tol_e4_locked", s_lk, 0);
        half(4);
        chk("tol_e5_locked", s_lk, 1);
        chk("tol_e5_hp", s_hp, 5);
        half(6);
        half(6);
        chk("tol6_mm", s_mm, 1);
        half(6);
        half(6);
        half(6);
        half(6);
        chk("tol6_locked", s_lk, 0);
        chk("tol6_hp", s_hp, 6);

        // New divider setting: EXPECT_DIV=5 matches half-period 6
        EXPECT_DIV = 8'd5;
        half(6);
        half(6);
        half(6);
        chk("div5_e3_locked", s_lk, 0);
        half(6);
        chk("div5_e4_locked", s_lk, 1);

        // Reset mid-lock
        RST = 1'b0;
        SD_CLK_IN = 1'b0;
        @(negedge CLK);
        chk("rstmid_locked", 32'(LOCKED), 0);
        chk("rstmid_hp", 32'(HALF_PERIOD), 0);
        chk("rstmid_lost", 32'(LOST), 0);
        chk("rstmid_strobes", 32'(RISE_STB | FALL_STB | MISMATCH), 0);
        @(negedge CLK);
        RST = 1'b1;
        EXPECT_DIV = 8'd3;
        @(negedge CLK);

        // CLR in the same cycle as an edge
        half(4);
        half(4);
        half(4);
        SD_CLK_IN = ~SD_CLK_IN;
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clredge_stb", 32'(RISE_STB | FALL_STB), 1);
        chk("clredge_hp", 32'(HALF_PERIOD), 0);
        @(negedge CLK);
        half(4);
        chk("clredge_idle_hp", s_hp, 0);
        half(4);
        half(4);
        half(4);
        chk("clredge_e4_locked", s_lk, 0);
        half(4);
        chk("clredge_e5_locked", s_lk, 1);

`ifdef SD_CLK_MON_DUTY_EN
        // Duty: high=3, low=5 never locks; high=low=4 locks cleanly
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        lk_seen = 0;
        du_seen = 0;
        for (int k = 0; k < 10; k++) half((SD_CLK_IN == 1'b0) ? 3 : 5);
        chk("duty_err_seen", 32'(du_seen > 0), 1);
        chk("duty_never_locked", 32'(lk_seen), 0);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        du_seen = 0;
        for (int k = 0; k < 8; k++) half(4);
        chk("duty_ok_locked", s_lk, 1);
        chk("duty_ok_no_err", 32'(du_seen), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
